// File: rtl/neuron_cache_pkg.sv
// Shared constants, FSM encoding and bank-rotation helper for the neuron
// cache write path.
package neuron_cache_pkg;

    localparam int CACHE_CHANNELS        = 7;
    localparam int CACHE_DEPTH_BIT_WIDTH = 5;
    localparam int REG_BIT_WIDTH         = 8;

    localparam logic [6:0] FIRST_BANK = 7'b1000000;
    localparam logic [2:0] MAX_FILTER = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_FREE = 2'd2,
        ST_DONE      = 2'd3
    } store_state_t;

    function automatic logic [6:0] next_bank(input logic [6:0] sel);
        return {sel[0], sel[6:1]};
    endfunction

endpackage

// File: rtl/neuron_store_credit.sv
// Free column-bank counter; flags a sticky error when the fetch side
// releases more banks than were ever filled.
module neuron_store_credit #(
    parameter int CHANNELS = 7,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             layer_reset,
    input  logic             consume_i,
    input  logic             release_i,
    output logic [CNT_W-1:0] free_next_o,
    output logic [CNT_W-1:0] free_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(CHANNELS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] free_q, free_d;
    logic             err_q, err_d;

    // Next free count; a simultaneous consume and release cancel out
    always_comb begin
        free_d = free_q;
        err_d  = err_q;
        if (consume_i && release_i) begin
            free_d = free_q;
        end else if (consume_i) begin
            if (free_q != CNT_ZERO) begin
                free_d = free_q - CNT_ONE;
            end else begin
                free_d = free_q;
            end
        end else if (release_i) begin
            if (free_q == FULL) begin
                err_d = 1'b1;
            end else begin
                free_d = free_q + CNT_ONE;
            end
        end else begin
            free_d = free_q;
        end
    end

    // Credit state registers
    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            free_q <= FULL;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

    assign free_next_o = free_d;
    assign free_o      = free_q;
    assign err_o       = err_q;

endmodule

// File: rtl/neuron_store.sv
// Writes a column-major pixel stream into rotating column banks of the
// neuron cache, stalling when every bank is still held by the fetch side.
module neuron_store #(
    parameter int CACHE_CHANNELS        = neuron_cache_pkg::CACHE_CHANNELS,
    parameter int CACHE_DEPTH_BIT_WIDTH = neuron_cache_pkg::CACHE_DEPTH_BIT_WIDTH,
    parameter int REG_BIT_WIDTH         = neuron_cache_pkg::REG_BIT_WIDTH
) (
    input  logic                             clk,
    input  logic                             layer_reset,
    input  logic                             start_i,
    input  logic [CACHE_DEPTH_BIT_WIDTH-1:0] picture_height_i,
    input  logic [CACHE_DEPTH_BIT_WIDTH-1:0] picture_width_i,
    input  logic [2:0]                       filter_width_i,
    input  logic                             in_valid_i,
    input  logic [REG_BIT_WIDTH-1:0]         in_data_i,
    output logic                             in_ready_o,
    input  logic                             column_release_i,
    output logic                             cache_wr_o,
    output logic [CACHE_DEPTH_BIT_WIDTH-1:0] wr_address_o,
    output logic [CACHE_CHANNELS-1:0]        wr_channel_sel_o,
    output logic [REG_BIT_WIDTH-1:0]         wr_data_o,
    output logic [2:0]                       filled_columns_o,
    output logic                             fetch_start_o,
    output logic                             done_o,
    output logic                             release_err_o
);

    import neuron_cache_pkg::*;

    localparam int AW    = CACHE_DEPTH_BIT_WIDTH;
    localparam int CNT_W = 3;
    localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0]    ADDR_ZERO = AW'(0);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(CACHE_CHANNELS);

    store_state_t             state_q, state_d;
    logic [AW-1:0]            row_q, row_d, col_q, col_d;
    logic [AW-1:0]            height_q, height_d, width_q, width_d;
    logic [2:0]               filt_q, filt_d;
    logic [CACHE_CHANNELS-1:0] sel_q, sel_d, wr_sel_q, wr_sel_d;
    logic                     pic_done_q, pic_done_d;
    logic                     cache_wr_q, cache_wr_d, in_ready_q, in_ready_d;
    logic                     done_q, done_d, fetch_q, fetch_d;
    logic [AW-1:0]            wr_addr_q, wr_addr_d;
    logic [REG_BIT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]         filled_q, filled_d;
    logic [CNT_W-1:0]         free_next_s, free_s;
    logic                     err_s, hs_s, col_complete_s, last_col_s;

    assign hs_s           = in_valid_i & in_ready_q;
    assign col_complete_s = hs_s & (row_q == height_q);
    assign last_col_s     = (col_q == width_q);

    neuron_store_credit #(
        .CHANNELS (CACHE_CHANNELS),
        .CNT_W    (CNT_W)
    ) u_credit (
        .clk         (clk),
        .layer_reset (layer_reset),
        .consume_i   (col_complete_s),
        .release_i   (column_release_i),
        .free_next_o (free_next_s),
        .free_o      (free_s),
        .err_o       (err_s)
    );

    // Write datapath, counters and FSM next state
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        sel_d      = sel_q;
        height_d   = height_q;
        width_d    = width_q;
        filt_d     = filt_q;
        pic_done_d = pic_done_q;
        cache_wr_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_sel_d   = wr_sel_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;

        if (hs_s) begin
            cache_wr_d = 1'b1;
            wr_addr_d  = row_q;
            wr_sel_d   = sel_q;
            wr_data_d  = in_data_i;
            row_d      = col_complete_s ? ADDR_ZERO : (row_q + ADDR_ONE);
        end else begin
            row_d = row_q;
        end

        if (col_complete_s) begin
            sel_d = next_bank(sel_q);
            col_d = col_q + ADDR_ONE;
        end else begin
            sel_d = sel_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_WRITE;
                    height_d   = picture_height_i;
                    width_d    = picture_width_i;
                    filt_d     = (filter_width_i > MAX_FILTER) ? MAX_FILTER : filter_width_i;
                    pic_done_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (col_complete_s && last_col_s) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    pic_done_d = 1'b1;
                end else if (col_complete_s && (free_next_s == CNT_W'(0))) begin
                    state_d = ST_WAIT_FREE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_FREE: begin
                if (free_s != CNT_W'(0)) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT_FREE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                row_d   = ADDR_ZERO;
                col_d   = ADDR_ZERO;
                sel_d   = FIRST_BANK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_WRITE);
        filled_d   = FULL - free_next_s;
        // After a finished picture the remaining columns must still be drained
        fetch_d    = (filled_d > filt_d) ||
                     (pic_done_d && (filled_d != CNT_W'(0)) &&
                      ((state_d == ST_DONE) || (state_d == ST_IDLE)));
    end

    // State and output registers
    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            state_q    <= ST_IDLE;
            row_q      <= ADDR_ZERO;
            col_q      <= ADDR_ZERO;
            sel_q      <= FIRST_BANK;
            height_q   <= ADDR_ZERO;
            width_q    <= ADDR_ZERO;
            filt_q     <= 3'd0;
            pic_done_q <= 1'b0;
            cache_wr_q <= 1'b0;
            wr_addr_q  <= ADDR_ZERO;
            wr_sel_q   <= FIRST_BANK;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            fetch_q    <= 1'b0;
            filled_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            sel_q      <= sel_d;
            height_q   <= height_d;
            width_q    <= width_d;
            filt_q     <= filt_d;
            pic_done_q <= pic_done_d;
            cache_wr_q <= cache_wr_d;
            wr_addr_q  <= wr_addr_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            fetch_q    <= fetch_d;
            filled_q   <= filled_d;
        end
    end

    assign in_ready_o       = in_ready_q;
    assign cache_wr_o       = cache_wr_q;
    assign wr_address_o     = wr_addr_q;
    assign wr_channel_sel_o = wr_sel_q;
    assign wr_data_o        = wr_data_q;
    assign filled_columns_o = filled_q;
    assign fetch_start_o    = fetch_q;
    assign done_o           = done_q;
    assign release_err_o    = err_s;

endmodule
